// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and the
// datapath plus data memory (slave).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [3:0]       opcode;
  logic             eq;
  logic             mem_ack;
  logic             ir_load;
  logic             pc_load;
  logic             pc_src;
  logic             RegDst;
  logic             RegWrite;
  logic             ALU_src;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic [2:0]       state;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, eq, mem_ack,
    output ir_load, pc_load, pc_src, RegDst, RegWrite, ALU_src,
           MemRead, MemWrite, MemToReg, state, halted, error, instr_count
  );

  modport slave (
    output run, opcode, eq, mem_ack,
    input  ir_load, pc_load, pc_src, RegDst, RegWrite, ALU_src,
           MemRead, MemWrite, MemToReg, state, halted, error, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the 16-bit MIPS datapath: per-phase enables,
// data-memory req/ack with timeout, and a saturating retired-instruction count.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | ir_load, instruction captured into IR
// DECODE | opcode latched into op_q
// EXEC   | ALU phase; branches/NOPs retire here, HALT enters HALT
// MEM    | LW/SW request held until mem_ack or timeout
// WB     | register write-back, PC advances
// HALT   | stopped until Clear
// ERROR  | memory timeout, stopped until Clear
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic Clear,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef struct packed {
    logic ir_load;
    logic pc_load;
    logic bne_exec;
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic halted;
    logic error;
  } outs_t;

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  state_t           state_q;
  state_t           state_nxt;
  logic [3:0]       op_q;
  logic [3:0]       op_nxt;
  logic [7:0]       tmo_cnt;
  outs_t            outs_q;
  logic [CNT_W-1:0] count_q;
  logic             pc_load_w;
  logic             retire;

  function automatic state_t next_state(input state_t s, input logic [3:0] op,
                                        input logic run, input logic ack,
                                        input logic [7:0] cnt);
    state_t ns;
    ns = s;
    case (s)
      S_IDLE:   ns = run ? S_FETCH : S_IDLE;
      S_FETCH:  ns = S_DECODE;
      S_DECODE: ns = S_EXEC;
      S_EXEC: begin
        if (!op[3])                      ns = S_WB;
        else if (op == OP_LW || op == OP_SW) ns = S_MEM;
        else if (op == OP_HALT)          ns = S_HALT;
        else                             ns = S_FETCH;
      end
      S_MEM: begin
        // an ack on the cycle the counter would expire still wins
        if (ack)                       ns = (op == OP_SW) ? S_FETCH : S_WB;
        else if (cnt + 8'd1 == TMO)    ns = S_ERROR;
        else                           ns = S_MEM;
      end
      S_WB:     ns = S_FETCH;
      S_HALT:   ns = S_HALT;
      default:  ns = S_ERROR;
    endcase
    return ns;
  endfunction

  function automatic outs_t outs_for(input state_t s, input logic [3:0] op);
    outs_t o;
    o = '0;
    case (s)
      S_FETCH: o.ir_load = 1'b1;
      S_EXEC: begin
        o.alu_src  = (op == OP_LW) || (op == OP_SW);
        o.bne_exec = (op == OP_BNE);
        o.pc_load  = (op == OP_BNE) || (op[3] && op[2:0] >= 3'd3 && op != OP_HALT);
      end
      S_MEM: begin
        o.alu_src   = 1'b1;
        o.mem_read  = (op == OP_LW);
        o.mem_write = (op == OP_SW);
      end
      S_WB: begin
        o.reg_write  = 1'b1;
        o.pc_load    = 1'b1;
        o.reg_dst    = !op[3];
        o.mem_to_reg = (op == OP_LW);
      end
      S_HALT:  o.halted = 1'b1;
      S_ERROR: begin
        o.halted = 1'b1;
        o.error  = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign state_nxt = next_state(state_q, op_q, bus.run, bus.mem_ack, tmo_cnt);
  assign op_nxt    = (state_q == S_DECODE) ? bus.opcode : op_q;

  // SW completion advances the PC in the same cycle the ack arrives
  assign pc_load_w = outs_q.pc_load |
                     ((state_q == S_MEM) && (op_q == OP_SW) && bus.mem_ack);
  assign retire    = pc_load_w | ((state_q == S_EXEC) && (op_q == OP_HALT));

  always_ff @(posedge clk) begin
    if (Clear) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      tmo_cnt <= 8'd0;
      outs_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      outs_q  <= outs_for(state_nxt, op_nxt);
      if (state_q == S_EXEC)
        tmo_cnt <= 8'd0;
      else if (state_q == S_MEM && !bus.mem_ack)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (retire && count_q != {CNT_W{1'b1}})
        count_q <= count_q + 1'b1;
    end
  end

  assign bus.ir_load     = outs_q.ir_load;
  assign bus.pc_load     = pc_load_w;
  assign bus.pc_src      = outs_q.bne_exec & ~bus.eq;
  assign bus.RegDst      = outs_q.reg_dst;
  assign bus.RegWrite    = outs_q.reg_write;
  assign bus.ALU_src     = outs_q.alu_src;
  assign bus.MemRead     = outs_q.mem_read;
  assign bus.MemWrite    = outs_q.mem_write;
  assign bus.MemToReg    = outs_q.mem_to_reg;
  assign bus.state       = state_q;
  assign bus.halted      = outs_q.halted;
  assign bus.error       = outs_q.error;
  assign bus.instr_count = count_q;

endmodule
